mem_req_ctrl: RTL and testbench

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

---
 rtl/mmu_pkg.sv | 14 +
 rtl/mem_req_ctrl_if.sv | 49 ++++
 rtl/mem_req_arb.sv | 36 +++
 rtl/mem_req_ctrl.sv | 102 ++++++++++
 tb/tb_mem_req_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mmu_pkg.sv
// Shared widths and FSM state encoding for the memory request controller.
package mmu_pkg;

  localparam int MMU_DATA_WIDTH = 512;
  localparam int MMU_MASK_WIDTH = MMU_DATA_WIDTH / 8;
  localparam int MMU_ADDR_WIDTH = 34;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RSP     = 2'd2
  } req_state_e;

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Request/response/memory-command bundle between the cache side, the controller and the memory macro.
interface mem_req_ctrl_if
  import mmu_pkg::*;
#(
  parameter int DATA_WIDTH = MMU_DATA_WIDTH,
  parameter int MASK_WIDTH = MMU_MASK_WIDTH,
  parameter int ADDR_WIDTH = MMU_ADDR_WIDTH
) ();

  logic                  i_rd_req_vld;
  logic                  o_rd_req_rdy;
  logic [ADDR_WIDTH-1:0] i_rd_req_addr;

  logic                  i_wr_req_vld;
  logic                  o_wr_req_rdy;
  logic [ADDR_WIDTH-1:0] i_wr_req_addr;
  logic [DATA_WIDTH-1:0] i_wr_req_data;
  logic [MASK_WIDTH-1:0] i_wr_req_mask;

  logic                  o_rd_rsp_vld;
  logic                  i_rd_rsp_rdy;
  logic [DATA_WIDTH-1:0] o_rd_rsp_data;

  logic                  o_wr_done;

  logic                  o_mem_cs;
  logic                  o_mem_wren;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_din;
  logic [MASK_WIDTH-1:0] o_mem_byte_mask;
  logic [DATA_WIDTH-1:0] i_mem_dout;

  modport slave (
    input  i_rd_req_vld, i_rd_req_addr,
    input  i_wr_req_vld, i_wr_req_addr, i_wr_req_data, i_wr_req_mask,
    input  i_rd_rsp_rdy, i_mem_dout,
    output o_rd_req_rdy, o_wr_req_rdy, o_rd_rsp_vld, o_rd_rsp_data, o_wr_done,
    output o_mem_cs, o_mem_wren, o_mem_addr, o_mem_din, o_mem_byte_mask
  );

  modport master (
    output i_rd_req_vld, i_rd_req_addr,
    output i_wr_req_vld, i_wr_req_addr, i_wr_req_data, i_wr_req_mask,
    output i_rd_rsp_rdy, i_mem_dout,
    input  o_rd_req_rdy, o_wr_req_rdy, o_rd_rsp_vld, o_rd_rsp_data, o_wr_done,
    input  o_mem_cs, o_mem_wren, o_mem_addr, o_mem_din, o_mem_byte_mask
  );

endinterface

// File: rtl/mem_req_arb.sv
// Two-way round-robin arbiter between read and write requests with a single last-grant bit.
module mem_req_arb (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic rd_vld,
  input  logic wr_vld,
  output logic gnt_rd,
  output logic gnt_wr
);

  logic last_wr_q;
  logic last_wr_d;

  // A grant is only issued to a valid requester, so a grant is itself the handshake.
  always_comb begin
    gnt_rd    = en && rd_vld && (!wr_vld || last_wr_q);
    gnt_wr    = en && wr_vld && (!rd_vld || !last_wr_q);
    last_wr_d = last_wr_q;
    if (gnt_rd) begin
      last_wr_d = 1'b0;
    end else if (gnt_wr) begin
      last_wr_d = 1'b1;
    end
  end

  // Reset to "write last" so the first contended grant goes to the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_wr_q <= 1'b1;
    end else begin
      last_wr_q <= last_wr_d;
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Single-port memory request controller: arbitrates line refills and writebacks, one read outstanding.
module mem_req_ctrl
  import mmu_pkg::*;
#(
  parameter int DATA_WIDTH = MMU_DATA_WIDTH,
  parameter int MASK_WIDTH = MMU_MASK_WIDTH,
  parameter int ADDR_WIDTH = MMU_ADDR_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  mem_req_ctrl_if.slave  bus
);

  req_state_e            state_q;
  logic                  rsp_vld_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  wr_done_q;

  logic                  arb_en;
  logic                  rd_hs;
  logic                  wr_hs;

  logic                  mem_cs;
  logic                  mem_wren;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [MASK_WIDTH-1:0] mem_mask;

  // Requests are only considered in IDLE and never while reset is held.
  assign arb_en = (state_q == ST_IDLE) && !rst;

  mem_req_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (arb_en),
    .rd_vld (bus.i_rd_req_vld),
    .wr_vld (bus.i_wr_req_vld),
    .gnt_rd (rd_hs),
    .gnt_wr (wr_hs)
  );

  always_comb begin
    mem_cs   = rd_hs | wr_hs;
    mem_wren = wr_hs;
    mem_addr = '0;
    mem_din  = '0;
    mem_mask = '0;
    if (wr_hs) begin
      mem_addr = bus.i_wr_req_addr;
      mem_din  = bus.i_wr_req_data;
      mem_mask = bus.i_wr_req_mask;
    end else if (rd_hs) begin
      mem_addr = bus.i_rd_req_addr;
    end
  end

  // Memory data arrives in RD_WAIT; it is latched into the only response buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
      wr_done_q  <= 1'b0;
    end else begin
      wr_done_q <= wr_hs;
      case (state_q)
        ST_IDLE: begin
          if (rd_hs) begin
            state_q <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          rsp_data_q <= bus.i_mem_dout;
          rsp_vld_q  <= 1'b1;
          state_q    <= ST_RSP;
        end
        ST_RSP: begin
          if (bus.i_rd_rsp_rdy) begin
            rsp_vld_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          rsp_vld_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_rd_req_rdy    = rd_hs;
  assign bus.o_wr_req_rdy    = wr_hs;
  assign bus.o_rd_rsp_vld    = rsp_vld_q;
  assign bus.o_rd_rsp_data   = rsp_data_q;
  assign bus.o_wr_done       = wr_done_q;
  assign bus.o_mem_cs        = mem_cs;
  assign bus.o_mem_wren      = mem_wren;
  assign bus.o_mem_addr      = mem_addr;
  assign bus.o_mem_din       = mem_din;
  assign bus.o_mem_byte_mask = mem_mask;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: a cycle table for arbitration plus hand-written multi-cycle sequences.
module tb_mem_req_ctrl;

  localparam int DW = 512;
  localparam int MW = 64;
  localparam int AW = 34;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_req_ctrl_if #(.DATA_WIDTH(DW), .MASK_WIDTH(MW), .ADDR_WIDTH(AW)) bus ();

  mem_req_ctrl #(.DATA_WIDTH(DW), .MASK_WIDTH(MW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Behavioural single-port memory with one-cycle read latency.
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] mem_dout = '0;
  logic [DW-1:0] wline;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  always @(posedge clk) begin
    if (bus.o_mem_cs) begin
      if (bus.o_mem_wren) begin
        wline = mem_rd(bus.o_mem_addr);
        for (int b = 0; b < MW; b++)
          if (bus.o_mem_byte_mask[b]) wline[b*8 +: 8] = bus.o_mem_din[b*8 +: 8];
        mem[bus.o_mem_addr] = wline;
      end else begin
        mem_dout <= mem_rd(bus.o_mem_addr);
      end
    end
  end
  assign bus.i_mem_dout = mem_dout;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h required %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  // {rd_rdy, wr_rdy, mem_cs, mem_wren, rsp_vld, wr_done}
  function automatic logic [5:0] outs6();
    return {bus.o_rd_req_rdy, bus.o_wr_req_rdy, bus.o_mem_cs, bus.o_mem_wren,
            bus.o_rd_rsp_vld, bus.o_wr_done};
  endfunction

  task automatic read_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
    int n;
    tick();
    bus.i_rd_req_vld = 1'b1; bus.i_rd_req_addr = a; bus.i_rd_rsp_rdy = 1'b1;
    settle();
    chk({nm, "_rdy"}, DW'(bus.o_rd_req_rdy), DW'(1'b1));
    tick();
    bus.i_rd_req_vld = 1'b0;
    settle();
    n = 0;
    while (!bus.o_rd_rsp_vld && n < 8) begin
      tick(); settle(); n++;
    end
    if (!bus.o_rd_rsp_vld) chk({nm, "_timeout"}, DW'(bus.o_rd_rsp_vld), DW'(1'b1));
    else chk({nm, "_data"}, bus.o_rd_rsp_data, exp);
  endtask

  typedef struct {
    logic       rd_vld;
    logic       wr_vld;
    logic       rsp_rdy;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs [13];

  logic [DW-1:0] a5_line, mixed_line;
  logic [AW-1:0] w_addr [4];
  logic [DW-1:0] w_data [4];
  logic [MW-1:0] w_mask [4];

  initial begin
    // Contended rd/wr with rsp_rdy high: grants alternate starting with read.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 6'b101000};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 6'b000000};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 6'b000010};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 6'b011100};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 6'b101001};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 6'b000000};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 6'b000010};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 6'b011100};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 6'b101001};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 6'b000000};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 6'b000010};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 6'b011100};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 6'b000001};

    a5_line    = {64{8'hA5}};
    mixed_line = {{56{8'hA5}}, {8{8'h3C}}};
    mem[34'h0_0000_0400] = a5_line;
    mem[34'h0_0000_0880] = {64{8'h77}};

    w_addr[0] = 34'h800; w_data[0] = {64{8'h11}}; w_mask[0] = '1;
    w_addr[1] = 34'h840; w_data[1] = {64{8'h22}}; w_mask[1] = '1;
    w_addr[2] = 34'h880; w_data[2] = {64{8'h33}}; w_mask[2] = '0;
    w_addr[3] = 34'h8C0; w_data[3] = {64{8'h44}}; w_mask[3] = '1;

    rst = 1'b1;
    bus.i_rd_req_vld  = 1'b1; bus.i_rd_req_addr = 34'h100;
    bus.i_wr_req_vld  = 1'b1; bus.i_wr_req_addr = 34'h200;
    bus.i_wr_req_data = {64{8'h5A}}; bus.i_wr_req_mask = '1;
    bus.i_rd_rsp_rdy  = 1'b1;

    repeat (2) tick();
    settle();
    chk("reset_outs", DW'(outs6()), DW'(6'b0));
    chk("reset_rsp_data", bus.o_rd_rsp_data, '0);
    chk("reset_mem_addr", DW'(bus.o_mem_addr), '0);

    for (int i = 0; i < 13; i++) begin
      tick();
      rst = 1'b0;
      bus.i_rd_req_vld = vecs[i].rd_vld;
      bus.i_wr_req_vld = vecs[i].wr_vld;
      bus.i_rd_rsp_rdy = vecs[i].rsp_rdy;
      settle();
      chk($sformatf("vec%0d", i), DW'(outs6()), DW'(vecs[i].exp));
    end

    // Read of a preloaded line: rsp_vld two cycles after the handshake.
    tick();
    bus.i_rd_req_vld = 1'b1; bus.i_rd_req_addr = 34'h400; bus.i_rd_rsp_rdy = 1'b1;
    settle();
    chk("rd_hs_outs", DW'(outs6()), DW'(6'b101000));
    chk("rd_hs_addr", DW'(bus.o_mem_addr), DW'(34'h400));
    chk("rd_hs_din_mask", DW'({bus.o_mem_din != '0, bus.o_mem_byte_mask != '0}), DW'(2'b00));
    tick();
    bus.i_rd_req_vld = 1'b0;
    settle();
    chk("rd_wait_vld", DW'(bus.o_rd_rsp_vld), DW'(1'b0));
    tick(); settle();
    chk("rd_rsp_vld", DW'(bus.o_rd_rsp_vld), DW'(1'b1));
    chk("rd_rsp_data", bus.o_rd_rsp_data, a5_line);

    // Partial-mask write, then a read of the same line on the very next cycle.
    tick();
    bus.i_wr_req_vld = 1'b1; bus.i_wr_req_addr = 34'h400;
    bus.i_wr_req_data = {64{8'h3C}}; bus.i_wr_req_mask = 64'h0000_0000_0000_00FF;
    settle();
    chk("wr_hs_outs", DW'(outs6()), DW'(6'b011100));
    chk("wr_hs_mask", DW'(bus.o_mem_byte_mask), DW'(64'hFF));
    chk("wr_hs_din", bus.o_mem_din, {64{8'h3C}});
    tick();
    bus.i_wr_req_vld = 1'b0;
    bus.i_rd_req_vld = 1'b1; bus.i_rd_req_addr = 34'h400;
    settle();
    chk("wr_done_rd_hs", DW'(outs6()), DW'(6'b101001));
    tick();
    bus.i_rd_req_vld = 1'b0;
    settle();
    chk("wr_done_once", DW'(bus.o_wr_done), DW'(1'b0));
    tick(); settle();
    chk("raw_rsp_vld", DW'(bus.o_rd_rsp_vld), DW'(1'b1));
    chk("raw_rsp_data", bus.o_rd_rsp_data, mixed_line);

    // Response back-pressure with both requesters asserting valid.
    tick();
    bus.i_rd_req_vld = 1'b1; bus.i_rd_req_addr = 34'h400; bus.i_rd_rsp_rdy = 1'b0;
    settle();
    chk("bp_rd_hs", DW'(bus.o_rd_req_rdy), DW'(1'b1));
    tick();
    bus.i_wr_req_vld = 1'b1;
    settle();
    for (int k = 0; k < 5; k++) begin
      tick(); settle();
      chk($sformatf("bp_hold%0d_outs", k), DW'(outs6()), DW'(6'b000010));
      chk($sformatf("bp_hold%0d_data", k), bus.o_rd_rsp_data, mixed_line);
    end
    tick();
    bus.i_rd_req_vld = 1'b0; bus.i_wr_req_vld = 1'b0; bus.i_rd_rsp_rdy = 1'b1;
    settle();
    chk("bp_release", DW'(bus.o_rd_rsp_vld), DW'(1'b1));
    tick(); settle();
    chk("bp_idle", DW'(bus.o_rd_rsp_vld), DW'(1'b0));

    // Reset while in RD_WAIT drops the read and restores read priority.
    tick();
    bus.i_rd_req_vld = 1'b1; bus.i_rd_req_addr = 34'h400;
    settle();
    chk("rst_rd_hs", DW'(bus.o_rd_req_rdy), DW'(1'b1));
    tick();
    rst = 1'b1; bus.i_wr_req_vld = 1'b1;
    settle();
    chk("rst_hold_outs", DW'(outs6()), DW'(6'b0));
    tick();
    rst = 1'b0; bus.i_rd_req_vld = 1'b0; bus.i_wr_req_vld = 1'b0;
    settle();
    chk("rst_after_outs", DW'(outs6()), DW'(6'b0));
    for (int k = 0; k < 3; k++) begin
      tick(); settle();
      chk($sformatf("rst_no_late_rsp%0d", k), DW'(bus.o_rd_rsp_vld), DW'(1'b0));
    end
    tick();
    bus.i_rd_req_vld = 1'b1; bus.i_wr_req_vld = 1'b1; bus.i_rd_req_addr = 34'h100;
    settle();
    chk("rst_prio", DW'({bus.o_rd_req_rdy, bus.o_wr_req_rdy}), DW'(2'b10));
    tick();
    bus.i_rd_req_vld = 1'b0; bus.i_wr_req_vld = 1'b0;
    tick();

    // Four back-to-back writes, the third with an all-zero mask.
    for (int w = 0; w < 4; w++) begin
      tick();
      bus.i_wr_req_vld = 1'b1; bus.i_wr_req_addr = w_addr[w];
      bus.i_wr_req_data = w_data[w]; bus.i_wr_req_mask = w_mask[w];
      settle();
      chk($sformatf("b2b_wr%0d_outs", w), DW'(outs6()), DW'({5'b01110, w > 0}));
      chk($sformatf("b2b_wr%0d_mask", w), DW'(bus.o_mem_byte_mask), DW'(w_mask[w]));
    end
    tick();
    bus.i_wr_req_vld = 1'b0;
    settle();
    chk("b2b_done_last", DW'(bus.o_wr_done), DW'(1'b1));
    tick(); settle();
    chk("b2b_done_end", DW'(bus.o_wr_done), DW'(1'b0));
    read_chk(34'h880, {64{8'h77}}, "zero_mask_unchanged");
    read_chk(34'h840, {64{8'h22}}, "b2b_wr1_data");
    read_chk(34'h8C0, {64{8'h44}}, "b2b_wr3_data");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
